// File: rtl/bitstream_serializer_pkg.sv
// Shared encodings for the entropy-encoder bitstream serializer: descriptor
// flags, descriptor header layout, FSM state codes and small decode helpers.
package bitstream_serializer_pkg;

  typedef logic [2:0] flag_t;

  localparam flag_t FLAG_NONE      = 3'd0;
  localparam flag_t FLAG_INVALID   = 3'd4;
  localparam flag_t FLAG_RUN       = 3'd5;
  localparam flag_t FLAG_RUN_B4    = 3'd6;
  localparam flag_t FLAG_RUN_B4_B5 = 3'd7;

  // Byte fields depend on the top-level width parameter, so only the
  // width-independent part of a descriptor lives here.
  typedef struct packed {
    flag_t flag;
    logic  last;
  } desc_hdr_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DIRECT = 2'd1;
  localparam state_t ST_RUN    = 2'd2;
  localparam state_t ST_TAIL   = 2'd3;

  // Number of leading bytes (bit_1..bit_n) emitted from DIRECT; 0 means a
  // zero-byte frame-end descriptor.
  function automatic logic [1:0] direct_len(input flag_t f);
    return (f < FLAG_INVALID) ? f[1:0] : 2'd1;
  endfunction

  function automatic logic has_tail(input flag_t f);
    return (f == FLAG_RUN_B4) || (f == FLAG_RUN_B4_B5);
  endfunction

endpackage

// File: rtl/bitstream_serializer_sync_fifo.sv
// Descriptor FIFO: pointer-pair FIFO with an extra wrap bit, combinational
// head read, push accepted when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bitstream_serializer.sv
// Expands entropy-encoder descriptors into a ready/valid byte stream with
// frame-end marking, byte counting and sticky error flags.
//
// state  | meaning
// IDLE   | FIFO empty, nothing presented
// DIRECT | emitting bit_1..bit_n of the head descriptor
// RUN    | repeating bit_2, run_cnt bytes left
// TAIL   | emitting bit_4, then bit_5 for flag 7
module bitstream_serializer
  import bitstream_serializer_pkg::*;
#(
  parameter int BITSTREAM_WIDTH = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       top_clk,
  input  logic                       top_reset,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                 in_flag_bitstream,
  input  logic                       in_flag_last,
  output logic [BITSTREAM_WIDTH-1:0] out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       out_frame_done,
  output logic [CNT_WIDTH-1:0]       out_byte_count,
  output logic                       err_overflow,
  output logic                       err_flag
);

  typedef struct packed {
    logic [BITSTREAM_WIDTH-1:0] bit_5;
    logic [BITSTREAM_WIDTH-1:0] bit_4;
    logic [BITSTREAM_WIDTH-1:0] bit_3;
    logic [BITSTREAM_WIDTH-1:0] bit_2;
    logic [BITSTREAM_WIDTH-1:0] bit_1;
    desc_hdr_t                  hdr;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);
  localparam int AW     = $clog2(FIFO_DEPTH);

  desc_t                      wr_desc;
  desc_t                      head;
  logic [DESC_W-1:0]          fifo_rdata;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [AW:0]                fifo_count;
  logic                       push_req;
  logic                       flag_bad;
  logic                       pop;

  state_t                     state;
  logic [1:0]                 idx;
  logic [BITSTREAM_WIDTH-1:0] run_cnt;
  logic [1:0]                 dlen;
  logic                       xfer;
  logic                       final_byte;
  logic                       zero_desc;
  logic                       desc_done;
  logic                       next_avail;

  assign flag_bad = (in_flag_bitstream == FLAG_INVALID);
  assign push_req = (!flag_bad && in_flag_bitstream != FLAG_NONE) || in_flag_last;

  // An invalid flag carrying last becomes a zero-byte frame-end descriptor.
  always_comb begin
    wr_desc          = '0;
    wr_desc.bit_1    = in_bit_1;
    wr_desc.bit_2    = in_bit_2;
    wr_desc.bit_3    = in_bit_3;
    wr_desc.bit_4    = in_bit_4;
    wr_desc.bit_5    = in_bit_5;
    wr_desc.hdr.flag = flag_bad ? FLAG_NONE : in_flag_bitstream;
    wr_desc.hdr.last = in_flag_last;
  end

  sync_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk   (top_clk),
    .reset (top_reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (wr_desc),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head = desc_t'(fifo_rdata);
  assign dlen = direct_len(head.hdr.flag);

  always_comb begin
    out_valid  = 1'b0;
    out_byte   = '0;
    final_byte = 1'b0;
    zero_desc  = 1'b0;
    case (state)
      ST_DIRECT: begin
        if (dlen == 2'd0) begin
          zero_desc = 1'b1;
        end else begin
          out_valid = 1'b1;
          case (idx)
            2'd0:    out_byte = head.bit_1;
            2'd1:    out_byte = head.bit_2;
            default: out_byte = head.bit_3;
          endcase
          final_byte = (idx == dlen - 2'd1)
                     && !(head.hdr.flag > FLAG_INVALID && head.bit_3 != '0)
                     && !has_tail(head.hdr.flag);
        end
      end
      ST_RUN: begin
        out_valid  = 1'b1;
        out_byte   = head.bit_2;
        final_byte = (run_cnt == BITSTREAM_WIDTH'(1)) && !has_tail(head.hdr.flag);
      end
      ST_TAIL: begin
        out_valid  = 1'b1;
        out_byte   = (idx == 2'd0) ? head.bit_4 : head.bit_5;
        final_byte = (idx != 2'd0) || (head.hdr.flag != FLAG_RUN_B4_B5);
      end
      default: ;
    endcase
  end

  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && final_byte && head.hdr.last;
  assign desc_done = zero_desc || (xfer && final_byte);
  assign pop       = desc_done;
  // Continue straight into DIRECT when another descriptor survives this pop.
  assign next_avail = (fifo_count[AW:1] != '0) || push_req;

  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      state          <= ST_IDLE;
      idx            <= 2'd0;
      run_cnt        <= '0;
      out_frame_done <= 1'b0;
      out_byte_count <= '0;
      err_overflow   <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      out_frame_done <= desc_done && head.hdr.last;
      err_flag       <= err_flag | flag_bad;
      err_overflow   <= err_overflow | (push_req && fifo_full && !pop);
      if (xfer) out_byte_count <= out_byte_count + 1'b1;

      if (desc_done) begin
        state <= next_avail ? ST_DIRECT : ST_IDLE;
        idx   <= 2'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            idx <= 2'd0;
            if (!fifo_empty) state <= ST_DIRECT;
          end
          ST_DIRECT: begin
            if (xfer) begin
              if (idx != dlen - 2'd1) begin
                idx <= idx + 2'd1;
              end else if (head.hdr.flag > FLAG_INVALID && head.bit_3 != '0) begin
                state   <= ST_RUN;
                run_cnt <= head.bit_3;
              end else begin
                state <= ST_TAIL;
                idx   <= 2'd0;
              end
            end
          end
          ST_RUN: begin
            if (xfer) begin
              run_cnt <= run_cnt - 1'b1;
              if (run_cnt == BITSTREAM_WIDTH'(1)) begin
                state <= ST_TAIL;
                idx   <= 2'd0;
              end
            end
          end
          ST_TAIL: begin
            if (xfer) idx <= 2'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitstream_serializer.sv
// Scoreboard bench: stimulus expands each descriptor into its expected byte
// list; a negedge monitor pops and compares every transferred byte.
module tb_bitstream_serializer;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = 32;

  logic          top_clk = 1'b0;
  logic          top_reset;
  logic [W-1:0]  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
  logic [2:0]    in_flag_bitstream;
  logic          in_flag_last;
  logic [W-1:0]  out_byte;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          out_frame_done;
  logic [CW-1:0] out_byte_count;
  logic          err_overflow;
  logic          err_flag;

  bitstream_serializer #(
    .BITSTREAM_WIDTH (W),
    .FIFO_DEPTH      (D),
    .CNT_WIDTH       (CW)
  ) dut (
    .top_clk           (top_clk),
    .top_reset         (top_reset),
    .in_bit_1          (in_bit_1),
    .in_bit_2          (in_bit_2),
    .in_bit_3          (in_bit_3),
    .in_bit_4          (in_bit_4),
    .in_bit_5          (in_bit_5),
    .in_flag_bitstream (in_flag_bitstream),
    .in_flag_last      (in_flag_last),
    .out_byte          (out_byte),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .out_frame_done    (out_frame_done),
    .out_byte_count    (out_byte_count),
    .err_overflow      (err_overflow),
    .err_flag          (err_flag)
  );

  always #5 top_clk = ~top_clk;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic       eod;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_total = 0;
  int   pushed_descs = 0;
  int   popped_descs = 0;
  int   zb_set = 0;
  int   zb_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference expansion straight from the flag rules.
  task automatic model_push(input logic [2:0] f, input logic l, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5);
    logic [7:0] seq[$];
    exp_t e;
    if (f == 3'd0 || f == 3'd4) begin
      if (l) zb_set++;
      return;
    end
    seq.push_back(b1);
    if (f < 3'd4) begin
      if (f >= 3'd2) seq.push_back(b2);
      if (f == 3'd3) seq.push_back(b3);
    end else begin
      for (int i = 0; i < int'(b3); i++) seq.push_back(b2);
      if (f >= 3'd6) seq.push_back(b4);
      if (f == 3'd7) seq.push_back(b5);
    end
    foreach (seq[i]) begin
      e.b    = seq[i];
      e.eod  = (i == seq.size() - 1);
      e.last = e.eod && l;
      exp_q.push_back(e);
    end
    exp_total += seq.size();
    pushed_descs++;
  endtask

  task automatic drive(input logic [2:0] f, input logic l, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                       input logic [7:0] b5, input bit model_en);
    in_flag_bitstream = f;
    in_flag_last      = l;
    in_bit_1 = b1; in_bit_2 = b2; in_bit_3 = b3; in_bit_4 = b4; in_bit_5 = b5;
    if (model_en) model_push(f, l, b1, b2, b3, b4, b5);
    @(posedge top_clk); #1;
    in_flag_bitstream = 3'd0;
    in_flag_last      = 1'b0;
    in_bit_1 = '0; in_bit_2 = '0; in_bit_3 = '0; in_bit_4 = '0; in_bit_5 = '0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge top_clk);
      c++;
    end
    #1;
    chk("drain_remaining", exp_q.size(), 0);
    repeat (3) @(posedge top_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},      out_valid, 1'b0);
    chk({tag, "_last"},       out_last, 1'b0);
    chk({tag, "_frame_done"}, out_frame_done, 1'b0);
    chk({tag, "_byte"},       out_byte, 8'h00);
    chk({tag, "_count"},      out_byte_count, 0);
    chk({tag, "_err_ovf"},    err_overflow, 1'b0);
    chk({tag, "_err_flag"},   err_flag, 1'b0);
  endtask

  // Monitor: in-order byte check, stall stability, frame_done timing.
  logic       hold_v = 1'b0;
  logic [7:0] hold_b;
  logic       hold_l;
  logic       fd_expect = 1'b0;

  always @(negedge top_clk) begin
    exp_t e;
    if (top_reset) begin
      exp_q.delete();
      hold_v    = 1'b0;
      fd_expect = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_byte",  out_byte,  hold_b);
        chk("stall_last",  out_last,  hold_l);
      end
      if (fd_expect) begin
        chk("frame_done", out_frame_done, 1'b1);
      end else if (out_frame_done) begin
        if (zb_seen < zb_set) zb_seen++;
        else chk("frame_done_spurious", out_frame_done, 1'b0);
      end
      fd_expect = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("byte", out_byte, e.b);
          chk("last", out_last, e.last);
          if (e.eod) popped_descs++;
          fd_expect = e.last;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_b = out_byte;
      hold_l = out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    logic [7:0] r1, r2, r3, r4, r5;
    int         sel;

    top_reset = 1'b1;
    out_ready = 1'b0;
    in_flag_bitstream = 3'd0;
    in_flag_last = 1'b0;
    in_bit_1 = '0; in_bit_2 = '0; in_bit_3 = '0; in_bit_4 = '0; in_bit_5 = '0;
    repeat (3) @(posedge top_clk);
    #1;
    check_reset_outputs("reset");
    top_reset = 1'b0;
    out_ready = 1'b1;
    @(posedge top_clk); #1;

    // Flag 3, latency from IDLE
    drive(3'd3, 1'b0, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b1);
    chk("latency_not_early", out_valid, 1'b0);
    @(posedge top_clk); #1;
    chk("latency_valid", out_valid, 1'b1);
    chk("latency_first_byte", out_byte, 8'h11);
    drain(50);
    chk("count_after_flag3", out_byte_count, exp_total);

    // Flag 7 with run of four
    drive(3'd7, 1'b0, 8'hA0, 8'hFF, 8'd4, 8'h12, 8'h34, 1'b1);
    drain(50);
    chk("count_after_flag7", out_byte_count, exp_total);

    // Flag 6 with empty run
    drive(3'd6, 1'b0, 8'h05, 8'h77, 8'd0, 8'h06, 8'h99, 1'b1);
    drain(50);
    chk("count_after_flag6", out_byte_count, exp_total);

    // Flag 2 with last, stall on the final byte
    drive(3'd2, 1'b1, 8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b1);
    @(posedge top_clk); #1;
    @(posedge top_clk); #1;
    out_ready = 1'b0;
    chk("stall_second_byte", out_byte, 8'hC3);
    chk("stall_second_last", out_last, 1'b1);
    @(posedge top_clk); #1;
    out_ready = 1'b1;
    drain(50);

    // Invalid flag: error only, then as a zero-byte frame end
    drive(3'd4, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b1);
    repeat (3) @(posedge top_clk); #1;
    chk("err_flag_set", err_flag, 1'b1);
    drive(3'd4, 1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b1);
    repeat (5) @(posedge top_clk); #1;
    chk("zero_byte_frame_done", zb_seen, zb_set);
    chk("count_after_invalid", out_byte_count, exp_total);

    // Overflow: nine pushes into an eight-deep FIFO with no drain
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      drive(3'd1, 1'b0, 8'(8'h40 + i), 8'h00, 8'h00, 8'h00, 8'h00, i < D);
    chk("err_overflow_set", err_overflow, 1'b1);
    drain(100);
    chk("count_after_overflow", out_byte_count, exp_total);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      r1 = 8'($urandom); r2 = 8'($urandom); r4 = 8'($urandom); r5 = 8'($urandom);
      if ($urandom_range(0, 9) < 4 && (pushed_descs - popped_descs) < D - 2) begin
        sel = int'($urandom_range(0, 5));
        f   = (sel < 3) ? 3'(sel + 1) : 3'(sel + 2);
        r3  = (f >= 3'd5) ? 8'($urandom_range(0, 5)) : 8'($urandom);
        drive(f, 1'($urandom_range(0, 1)), r1, r2, r3, r4, r5, 1'b1);
      end else begin
        r3 = 8'($urandom);
        drive(($urandom_range(0, 3) == 0) ? 3'd4 : 3'd0, 1'b0, r1, r2, r3, r4, r5, 1'b1);
      end
    end
    drain(500);
    chk("count_after_random", out_byte_count, exp_total);

    // Reset in the middle of a long run
    drive(3'd5, 1'b1, 8'hE1, 8'hE2, 8'd200, 8'h00, 8'h00, 1'b1);
    repeat (20) @(posedge top_clk);
    #1;
    top_reset = 1'b1;
    out_ready = 1'b0;
    @(posedge top_clk); #1;
    check_reset_outputs("midrun_reset");
    @(posedge top_clk); #1;
    top_reset    = 1'b0;
    exp_total    = 0;
    pushed_descs = popped_descs;
    zb_set       = zb_seen;
    out_ready    = 1'b1;
    repeat (30) @(posedge top_clk);
    #1;
    chk("post_reset_valid", out_valid, 1'b0);
    chk("post_reset_count", out_byte_count, exp_total);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bitstream_serializer.md
BITSTREAM_SERIALIZER -- requirements
Module: bitstream_serializer

Interface
REQ-001 The block SHALL have parameter BITSTREAM_WIDTH, default 8, giving the width of one output byte.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the descriptor FIFO depth (power of 2, at least 2).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 32, giving the byte-counter width.
REQ-004 The block SHALL have port top_clk, input, width 1: the single clock; all logic on the rising edge.
REQ-005 The block SHALL have port top_reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have ports in_bit_1 to in_bit_5, input, width BITSTREAM_WIDTH each: entropy_encoder OUT_BIT_1_1 to OUT_BIT_1_5.
REQ-007 The block SHALL have port in_flag_bitstream, input, width 3: entropy_encoder OUT_FLAG_BITSTREAM_1.
REQ-008 The block SHALL have port in_flag_last, input, width 1: entropy_encoder OUT_FLAG_LAST.
REQ-009 The block SHALL have port out_byte, output, width BITSTREAM_WIDTH: the serialized byte.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the downstream handshake.
REQ-011 The block SHALL have port out_last, output, width 1: set with the final byte of a frame.
REQ-012 The block SHALL have port out_frame_done, output, width 1: one-cycle pulse when a frame's last descriptor is fully drained.
REQ-013 The block SHALL have port out_byte_count, output, width CNT_WIDTH: bytes transferred since reset.
REQ-014 The block SHALL have ports err_overflow and err_flag, outputs, width 1 each: sticky error flags.

Function
REQ-015 The block SHALL sample the inputs every cycle; it has no upstream backpressure.
REQ-016 A descriptor SHALL be pushed to the FIFO when in_flag_bitstream is not 0, or when in_flag_last is 1.
REQ-017 A descriptor SHALL store bit_1 to bit_5, the flag and the last bit.
REQ-018 Flag 1, 2 or 3 SHALL emit bit_1 up to bit_<flag>, in order.
REQ-019 Flag 5 SHALL emit bit_1, then bit_2 repeated bit_3 times (unsigned count, 0 to 255).
REQ-020 Flag 6 SHALL do the same as flag 5, then emit bit_4.
REQ-021 Flag 7 SHALL do the same as flag 6, then emit bit_5.
REQ-022 Flag 4 SHALL NOT be pushed; err_flag SHALL be set, and in_flag_last in that cycle still produces a zero-byte last descriptor.
REQ-023 The state machine SHALL have states IDLE, DIRECT, RUN and TAIL.
- IDLE: go to DIRECT when the FIFO is not empty.
- DIRECT: emit bit_1 to bit_n (n = flag when flag < 4, n = 1 when flag > 4); go to RUN if flag > 4 and bit_3 > 0; go to TAIL if flag is 6 or 7 and bit_3 = 0; otherwise the descriptor is done.
- RUN: repeat bit_2 using a down-counter loaded with bit_3; at zero, go to TAIL if flag is 6 or 7, otherwise the descriptor is done.
- TAIL: emit bit_4, then bit_5 if flag = 7; then the descriptor is done.
REQ-024 A byte SHALL advance only on a cycle where out_valid and out_ready are both 1; out_byte and out_last SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-025 A descriptor SHALL be popped in the same cycle its final byte transfers; the next descriptor SHALL be presented in the following cycle, with no bubble, giving 1 byte per cycle.
REQ-026 Latency: a descriptor sampled at edge k SHALL show its first byte with out_valid = 1 after edge k+1 when the FIFO was empty and the block was in IDLE.
REQ-027 out_last SHALL equal 1 only on the final byte of a descriptor whose last bit is 1.
REQ-028 out_frame_done SHALL pulse in the cycle after that final byte transfers.
REQ-029 A zero-byte last descriptor SHALL be popped without driving out_valid, and out_frame_done SHALL pulse in the cycle after the pop.
REQ-030 A push while the FIFO is full and no pop occurs SHALL drop the descriptor and set err_overflow.
REQ-031 A push while the FIFO is full and a pop occurs in the same cycle SHALL be accepted.
REQ-032 A push and a pop on an empty FIFO SHALL NOT occur together; the pop requires an occupied entry.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH and use an extra bit to tell full from empty.
REQ-034 out_byte_count SHALL increment by 1 per transferred byte and wrap modulo 2^CNT_WIDTH.

Reset
REQ-035 While top_reset = 1 at an edge, FIFO, pointers, state and counters SHALL clear, with state = IDLE.
REQ-036 On reset: out_valid = 0, out_last = 0, out_frame_done = 0, out_byte = 0, out_byte_count = 0, err_overflow = 0, err_flag = 0.
REQ-037 A reset in mid-descriptor or mid-RUN SHALL discard all pending bytes with no partial output afterwards; inputs present during reset SHALL be ignored.

Structure
REQ-038 A shared package (e.g. entropy_pkg) SHALL hold the flag encodings (FLAG_NONE = 0, FLAG_INVALID = 4, FLAG_RUN = 5, FLAG_RUN_B4 = 6, FLAG_RUN_B4_B5 = 7), the descriptor struct typedef and the state enum.
REQ-039 A single sub-module, sync_fifo (parameterized width and depth, registered read data not required), SHALL hold the descriptors; the expansion FSM SHALL stay in bitstream_serializer.

Verification
REQ-040 Flag 3 with bytes 0x11, 0x22, 0x33 and out_ready = 1 -> out_byte 0x11, 0x22, 0x33 on consecutive cycles, first after edge k+1; out_byte_count = 3.
REQ-041 Flag 7 with b1 = 0xA0, b2 = 0xFF, b3 = 4, b4 = 0x12, b5 = 0x34 -> A0, FF, FF, FF, FF, 12, 34, 7 bytes in total.
REQ-042 Flag 6 with b3 = 0 and b1 = 0x05, b4 = 0x06 -> 0x05, 0x06 only.
REQ-043 Flag 2 with in_flag_last = 1 and out_ready toggled 1, 0, 1 -> second byte held stable while stalled, out_last = 1 on it, out_frame_done pulses on the next cycle.
REQ-044 out_ready = 0 with 9 consecutive flag-1 inputs (FIFO_DEPTH = 8) -> err_overflow = 1, and after release exactly 8 bytes emerge in order.
REQ-045 Flag 4 input -> err_flag = 1 and no byte emitted; reset asserted during a RUN of b3 = 200 -> out_valid = 0 the next cycle and all outputs at their reset values.
